// File: rtl/knn_vote.sv
// knn_vote: majority vote over the K nearest-neighbour labels. Ties go to the
// class whose first vote came from the nearest neighbour.
// Latency: start -> result is 1 + K + N_CLASS cycles minimum (one ACCUM cycle
// per accepted label, then one SCAN cycle per class).
// Backpressure: nb_ready is high only in ACCUM, so gaps on nb_valid stall the
// run. vote_valid is held until vote_ready.
// Ports: clk, rst (sync, active-high), start, nb_valid/nb_ready/nb_label,
// vote_valid/vote_ready/vote_label/vote_count, busy, and vote_err (only when
// KNN_VOTE_ERR_EN is defined).
// Optional feature macro: KNN_VOTE_ERR_EN adds the sticky out-of-range flag vote_err.
module knn_vote #(
  parameter  int K       = 4,
  parameter  int N_CLASS = 8,
  parameter  int LABEL_W = 3,
  localparam int CNT_W   = $clog2(K + 1),
  localparam int RANK_W  = (K > 1) ? $clog2(K) : 1,
  localparam int IDX_W   = $clog2(N_CLASS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               nb_valid,
  output logic               nb_ready,
  input  logic [LABEL_W-1:0] nb_label,
  output logic               vote_valid,
  input  logic               vote_ready,
  output logic [LABEL_W-1:0] vote_label,
  output logic [CNT_W-1:0]   vote_count,
`ifdef KNN_VOTE_ERR_EN
  output logic               vote_err,
`endif
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt        [N_CLASS];
  logic [RANK_W-1:0]   first_rank [N_CLASS];  // meaningful only while cnt != 0
  logic [RANK_W-1:0]   rank;                  // position of the next label, 0 = nearest
  logic [IDX_W-1:0]    idx;                   // class under evaluation in SCAN
  logic [LABEL_W-1:0]  best_label;
  logic [CNT_W-1:0]    best_cnt;
  logic [RANK_W-1:0]   best_first;

  logic                accept;
  logic                in_range;
  logic [IDX_W-1:0]    lbl_idx;
  logic                take;
  logic [LABEL_W-1:0]  nxt_label;
  logic [CNT_W-1:0]    nxt_cnt;
  logic [RANK_W-1:0]   nxt_first;

  assign accept   = nb_valid & nb_ready;
  assign in_range = (32'(nb_label) < N_CLASS);
  assign lbl_idx  = IDX_W'(nb_label);

  // Scan comparison: a higher count wins outright. On an equal, non-zero
  // count the class whose first vote was nearer wins. Because best starts at
  // count 0, a class with no votes never displaces it.
  always_comb begin
    take      = 1'b0;
    nxt_label = best_label;
    nxt_cnt   = best_cnt;
    nxt_first = best_first;
    if (cnt[idx] > best_cnt) begin
      take = 1'b1;
    end else if ((cnt[idx] == best_cnt) && (cnt[idx] != '0) &&
                 (first_rank[idx] < best_first)) begin
      take = 1'b1;
    end
    if (take) begin
      nxt_label = LABEL_W'(idx);
      nxt_cnt   = cnt[idx];
      nxt_first = first_rank[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      nb_ready   <= 1'b0;
      vote_valid <= 1'b0;
      busy       <= 1'b0;
      vote_label <= '0;
      vote_count <= '0;
      rank       <= '0;
      idx        <= '0;
      best_label <= '0;
      best_cnt   <= '0;
      best_first <= '0;
      for (int c = 0; c < N_CLASS; c++) begin
        cnt[c]        <= '0;
        first_rank[c] <= '0;
      end
`ifdef KNN_VOTE_ERR_EN
      vote_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rank       <= '0;
            idx        <= '0;
            best_label <= '0;
            best_cnt   <= '0;
            best_first <= '0;
            for (int c = 0; c < N_CLASS; c++) begin
              cnt[c] <= '0;
            end
`ifdef KNN_VOTE_ERR_EN
            vote_err   <= 1'b0;
`endif
            nb_ready   <= 1'b1;
            busy       <= 1'b1;
            state      <= ACCUM;
          end
        end

        ACCUM: begin
          if (accept) begin
            if (in_range) begin
              if (cnt[lbl_idx] == '0) begin
                first_rank[lbl_idx] <= rank;
              end
              // At most K accepts per run, so saturation is only a guard.
              if (cnt[lbl_idx] != CNT_W'(K)) begin
                cnt[lbl_idx] <= cnt[lbl_idx] + 1'b1;
              end
            end
`ifdef KNN_VOTE_ERR_EN
            else begin
              vote_err <= 1'b1;
            end
`endif
            // Out-of-range labels still consume a neighbour slot.
            rank <= rank + 1'b1;
            if (rank == RANK_W'(K - 1)) begin
              nb_ready <= 1'b0;
              idx      <= '0;
              state    <= SCAN;
            end
          end
        end

        SCAN: begin
          best_label <= nxt_label;
          best_cnt   <= nxt_cnt;
          best_first <= nxt_first;
          idx        <= idx + 1'b1;
          if (idx == IDX_W'(N_CLASS - 1)) begin
            vote_label <= nxt_label;
            vote_count <= nxt_cnt;
            vote_valid <= 1'b1;
            state      <= DONE;
          end
        end

        DONE: begin
          // A start in the same cycle as vote_ready is deliberately dropped.
          if (vote_ready) begin
            vote_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
module tb_knn_vote;
  localparam int K = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       nb_valid;
  logic [2:0] nb_label;
  logic       vote_ready;
  logic       sel;  // 0: N_CLASS=8 instance, 1: N_CLASS=6 instance

  logic       rdy8, vv8, busy8;
  logic [2:0] vl8, vc8;
  logic       rdy6, vv6, busy6;
  logic [2:0] vl6, vc6;
`ifdef KNN_VOTE_ERR_EN
  logic       err8, err6;
`endif

  knn_vote #(.K(K), .N_CLASS(8), .LABEL_W(3)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start & ~sel),
    .nb_valid   (nb_valid & ~sel),
    .nb_ready   (rdy8),
    .nb_label   (nb_label),
    .vote_valid (vv8),
    .vote_ready (vote_ready & ~sel),
    .vote_label (vl8),
    .vote_count (vc8),
`ifdef KNN_VOTE_ERR_EN
    .vote_err   (err8),
`endif
    .busy       (busy8)
  );

  knn_vote #(.K(K), .N_CLASS(6), .LABEL_W(3)) u_dut6 (
    .clk        (clk),
    .rst        (rst),
    .start      (start & sel),
    .nb_valid   (nb_valid & sel),
    .nb_ready   (rdy6),
    .nb_label   (nb_label),
    .vote_valid (vv6),
    .vote_ready (vote_ready & sel),
    .vote_label (vl6),
    .vote_count (vc6),
`ifdef KNN_VOTE_ERR_EN
    .vote_err   (err6),
`endif
    .busy       (busy6)
  );

  logic       o_rdy, o_vv, o_busy;
  logic [2:0] o_vl, o_vc;
  assign o_rdy  = sel ? rdy6  : rdy8;
  assign o_vv   = sel ? vv6   : vv8;
  assign o_busy = sel ? busy6 : busy8;
  assign o_vl   = sel ? vl6   : vl8;
  assign o_vc   = sel ? vc6   : vc8;
`ifdef KNN_VOTE_ERR_EN
  logic o_err;
  assign o_err = sel ? err6 : err8;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: count votes per class, then walk the neighbours nearest first
  // and keep a class only if it strictly beats the best count so far. The
  // earliest-seen class therefore wins every tie.
  task automatic model(input int labs[K], input int nc,
                       output int el, output int ec, output int ee);
    int votes[8];
    el = 0; ec = 0; ee = 0;
    for (int c = 0; c < 8; c++) votes[c] = 0;
    for (int i = 0; i < K; i++) begin
      if (labs[i] < nc) votes[labs[i]]++;
      else ee = 1;
    end
    for (int i = 0; i < K; i++) begin
      if (labs[i] < nc && votes[labs[i]] > ec) begin
        ec = votes[labs[i]];
        el = labs[i];
      end
    end
  endtask

  // gaps: 0 = valid every cycle, 1 = random, 2 = pattern 1,0,0,1,0,0,...
  task automatic run(input int labs[K], input int gaps, input int rdy_dly,
                     input int junk_start, input int chk_lat);
    int el, ec, ee, nc, i, cyc, s;
    logic acc;
    nc = sel ? 6 : 8;
    model(labs, nc, el, ec, ee);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    chk("accum_ready", o_rdy, 1);
    chk("accum_busy", o_busy, 1);
    i = 0;
    s = 0;
    while (i < K && cyc < 300) begin
      case (gaps)
        0:       nb_valid = 1'b1;
        1:       nb_valid = 1'($urandom_range(0, 1));
        default: nb_valid = (s % 3 == 0);
      endcase
      s++;
      nb_label = 3'(labs[i]);
      start = junk_start ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = nb_valid & o_rdy;
      tick();
      cyc++;
      if (acc) i++;
    end
    nb_valid = 1'b0;
    if (i < K) chk("feed_timeout", i, K);
    while (!o_vv && cyc < 300) begin
      start = junk_start ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("result_valid", o_vv, 1);
    if (chk_lat) chk("latency", cyc, 1 + K + nc);
    chk("vote_label", o_vl, el);
    chk("vote_count", o_vc, ec);
`ifdef KNN_VOTE_ERR_EN
    chk("vote_err", o_err, ee);
`endif
    for (int d = 0; d < rdy_dly; d++) begin
      tick();
      chk("hold_valid", o_vv, 1);
      chk("hold_label", o_vl, el);
      chk("hold_count", o_vc, ec);
    end
    vote_ready = 1'b1;
    start = junk_start ? 1'b1 : 1'b0;
    tick();
    vote_ready = 1'b0;
    start = 1'b0;
    chk("release_valid", o_vv, 0);
    chk("release_busy", o_busy, 0);
    tick();
    chk("start_dropped", o_busy, 0);
    chk("label_held", o_vl, el);
  endtask

  initial begin
    int L[K];
    rst = 1'b1; start = 1'b0; nb_valid = 1'b0; nb_label = '0;
    vote_ready = 1'b0; sel = 1'b0;
    repeat (3) tick();
    chk("rst_ready", rdy8 | rdy6, 0);
    chk("rst_valid", vv8 | vv6, 0);
    chk("rst_busy", busy8 | busy6, 0);
    chk("rst_label", vl8 | vl6, 0);
    chk("rst_count", vc8 | vc6, 0);
`ifdef KNN_VOTE_ERR_EN
    chk("rst_err", err8 | err6, 0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_ready", rdy8, 0);

    L = '{3, 3, 5, 1}; run(L, 0, 0, 0, 1);
    L = '{6, 2, 2, 6}; run(L, 0, 1, 0, 1);
    L = '{4, 7, 0, 1}; run(L, 0, 0, 0, 1);
    L = '{5, 5, 5, 2}; run(L, 2, 5, 0, 0);

    // Abort after two accepts; the next run must show no residue.
    start = 1'b1; tick(); start = 1'b0;
    nb_valid = 1'b1; nb_label = 3'd4; tick(); tick();
    nb_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_ready", rdy8, 0);
    chk("abort_busy", busy8, 0);
    chk("abort_label", vl8, 0);
    tick();
    L = '{1, 1, 1, 1}; run(L, 0, 0, 1, 1);

    sel = 1'b1;
    L = '{7, 2, 6, 3}; run(L, 0, 1, 0, 1);
    sel = 1'b0;

    for (int n = 0; n < 30; n++) begin
      int r;
      sel = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 1) == 1) ? 2 : 7;
      for (int j = 0; j < K; j++) L[j] = $urandom_range(0, r);
      begin
        int g;
        g = $urandom_range(0, 1);
        run(L, g, $urandom_range(0, 3), $urandom_range(0, 1), (g == 0));
      end
    end
    sel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
